// File: rtl/csrb_pkg.sv
// Shared definitions for the byte-granular right rotator (circular_shifter_right_byte_n).
// Provides the byte width, a lane-count helper and a plain reference rotate function.
package csrb_pkg;

    localparam int BYTE_W = 8;

    // Widest word the reference function accepts; callers pass the live width in n.
    localparam int MAX_N = 1024;

    // Number of byte lanes in an n-bit word.
    function automatic int lanes(input int n);
        return n / BYTE_W;
    endfunction

    // Reference rotate: output byte k takes input byte (k + amt) mod lanes(n).
    // Bits above n are returned as zero.
    function automatic logic [MAX_N-1:0] rot_bytes_r(input logic [MAX_N-1:0] word,
                                                     input int              amt,
                                                     input int              n);
        logic [MAX_N-1:0] res;
        int               l;
        res = '0;
        l   = lanes(n);
        for (int k = 0; k < MAX_N / BYTE_W; k++) begin
            if (k < l) begin
                res[k*BYTE_W +: BYTE_W] = word[((k + amt) % l)*BYTE_W +: BYTE_W];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/csrb_rotate_stage.sv
// One stage of the log2 byte barrel: rotates din right by STEP bytes when en is
// high, otherwise passes din through untouched. Purely combinational.
module csrb_rotate_stage
    import csrb_pkg::*;
#(
    parameter int N    = 128,
    parameter int STEP = 1
) (
    input  logic [N-1:0] din,
    input  logic         en,
    output logic [N-1:0] dout
);

    // The low STEP bytes fall off the LSB end and re-enter at the MSB end.
    logic [N-1:0] rotated;

    assign rotated = {din[STEP*BYTE_W-1:0], din[N-1:STEP*BYTE_W]};
    assign dout    = en ? rotated : din;

endmodule

// File: rtl/circular_shifter_right_byte_n.sv
// Byte-granular right rotator: out byte k = in byte ((k + shift_amount) mod N/8).
// Built as a log2 barrel of csrb_rotate_stage instances chained LSB-first.
// Default build registers the result with one cycle of latency and a valid flop.
// Optional macro CSRB_COMB_OUT_EN bypasses the output register: shifted follows the
// current inputs combinationally and out_valid = in_valid (clk/rst_n unused).
// N must be a multiple of 8 and at least 16.
module circular_shifter_right_byte_n
    import csrb_pkg::*;
#(
    parameter int N = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [N-1:0]           shifting,
    input  logic [$clog2(N/8)-1:0] shift_amount,
    output logic [N-1:0]           shifted,
    output logic                   out_valid
);

    localparam int LANES = lanes(N);
    localparam int SA_W  = $clog2(LANES);

    // stage_data[j] is the word entering stage j; stage_data[SA_W] is fully rotated.
    logic [N-1:0] stage_data [0:SA_W];

    assign stage_data[0] = shifting;

    // Stage j rotates by 2^j bytes when bit j of the amount is set, so the stages
    // together rotate by exactly shift_amount bytes.
    for (genvar j = 0; j < SA_W; j++) begin : g_stage
        csrb_rotate_stage #(
            .N    (N),
            .STEP (1 << j)
        ) u_stage (
            .din  (stage_data[j]),
            .en   (shift_amount[j]),
            .dout (stage_data[j+1])
        );
    end

`ifdef CSRB_COMB_OUT_EN

    // Clock and reset are kept as ports for drop-in compatibility but drive nothing.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign shifted   = stage_data[SA_W];
    assign out_valid = in_valid;

`else

    // Capture the rotated word only on accepted inputs so idle cycles neither toggle
    // the output nor let unknown idle data leak in; the valid flop tracks in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shifted   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                shifted <= stage_data[SA_W];
            end
        end
    end

`endif

endmodule

// File: tb/tb_circular_shifter_right_byte_n.sv
// Self-checking bench for circular_shifter_right_byte_n (N = 128).
// Reference model: ({w,w} >> 8*amt) truncated to N bits, tracked per clock edge.
// Honours CSRB_COMB_OUT_EN to expect the zero-latency combinational variant.
module tb_circular_shifter_right_byte_n;
    import csrb_pkg::*;

    localparam int N    = 128;
    localparam int L    = N / 8;
    localparam int SA_W = $clog2(L);

    localparam logic [N-1:0] BASE_WORD = 128'hFFEEDDCCBBAA99887766554433221100;
    localparam logic [N-1:0] ROT1      = 128'h00FFEEDDCCBBAA998877665544332211;
    localparam logic [N-1:0] ROT2      = 128'h1100FFEEDDCCBBAA9988776655443322;
    localparam logic [N-1:0] ROT3      = 128'h221100FFEEDDCCBBAA99887766554433;
    localparam logic [N-1:0] ROT15     = 128'hEEDDCCBBAA99887766554433221100FF;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic [N-1:0]    shifting;
    logic [SA_W-1:0] shift_amount;
    logic [N-1:0]    shifted;
    logic            out_valid;

    int errors;
    int checks;
    bit chk_en;

    logic [N-1:0] mdl_shifted;
    logic         mdl_valid;

    circular_shifter_right_byte_n #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .shifting     (shifting),
        .shift_amount (shift_amount),
        .shifted      (shifted),
        .out_valid    (out_valid)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rotate right by whole bytes via the doubled-word shift.
    function automatic logic [N-1:0] model_rot(input logic [N-1:0] w, input int amt);
        logic [2*N-1:0] d;
        d = {w, w} >> (8 * amt);
        return d[N-1:0];
    endfunction

    // Expected registered output state; reset clears it at once.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_valid   <= 1'b0;
            mdl_shifted <= '0;
        end else begin
            mdl_valid <= in_valid;
            if (in_valid === 1'b1) begin
                mdl_shifted <= model_rot(shifting, int'(shift_amount));
            end
        end
    end

    // Per-cycle comparison of the DUT against the model, midway between edges.
    always @(negedge clk) begin
        if (chk_en) begin
`ifdef CSRB_COMB_OUT_EN
            checks++;
            if (out_valid !== in_valid) begin
                errors++;
                $display("[TB] FAIL cyc_valid: got %b want %b", out_valid, in_valid);
            end
            if (in_valid === 1'b1) begin
                checks++;
                if (shifted !== model_rot(shifting, int'(shift_amount))) begin
                    errors++;
                    $display("[TB] FAIL cyc_data: got %h want %h", shifted,
                             model_rot(shifting, int'(shift_amount)));
                end
            end
`else
            checks++;
            if (out_valid !== mdl_valid) begin
                errors++;
                $display("[TB] FAIL cyc_valid: got %b want %b", out_valid, mdl_valid);
            end
            checks++;
            if (shifted !== mdl_shifted) begin
                errors++;
                $display("[TB] FAIL cyc_data: got %h want %h", shifted, mdl_shifted);
            end
`endif
        end
    end

    // Drive one set of inputs.
    task automatic applyStimulus(input logic [N-1:0] w, input logic [SA_W-1:0] a, input logic v);
        shifting     = w;
        shift_amount = a;
        in_valid     = v;
    endtask

    // Compare the DUT outputs with literal expectations.
    task automatic checkOutput(input string name, input logic [N-1:0] exp_w, input logic exp_v);
        checks++;
        if (out_valid !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s_valid: got %b want %b", name, out_valid, exp_v);
        end
        checks++;
        if (shifted !== exp_w) begin
            errors++;
            $display("[TB] FAIL %s_data: got %h want %h", name, shifted, exp_w);
        end
    endtask

    // Compare the bench model with a hand-computed rotation.
    task automatic checkModel(input string name, input int amt, input logic [N-1:0] exp_w);
        logic [N-1:0] got;
        got = model_rot(BASE_WORD, amt);
        checks++;
        if (got !== exp_w) begin
            errors++;
            $display("[TB] FAIL %s: got %h want %h", name, got, exp_w);
        end
    endtask

    // Wait until an applied input is visible at the outputs.
    task automatic settle();
`ifdef CSRB_COMB_OUT_EN
        #1;
`else
        @(posedge clk);
        #1;
`endif
    endtask

    // Apply one valid input and check its literal result.
    task automatic stepCheck(input string name, input logic [SA_W-1:0] a, input logic [N-1:0] exp_w);
        @(posedge clk);
        #2;
        applyStimulus(BASE_WORD, a, 1'b1);
        settle();
        checkOutput(name, exp_w, 1'b1);
    endtask

    initial begin
        logic [N-1:0]    w;
        logic [SA_W-1:0] a;
        logic [N-1:0]    pkg_res;
        errors = 0;
        checks = 0;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        applyStimulus('0, '0, 1'b0);

        checkModel("model_amt0", 0, BASE_WORD);
        checkModel("model_amt1", 1, ROT1);
        checkModel("model_amt3", 3, ROT3);
        checkModel("model_amt15", 15, ROT15);

        #1;
        checkOutput("reset", '0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        stepCheck("basic_amt3", 4'd3, ROT3);
        stepCheck("amt0", 4'd0, BASE_WORD);
        stepCheck("amt1", 4'd1, ROT1);
        stepCheck("amt15", 4'd15, ROT15);

`ifndef CSRB_COMB_OUT_EN
        // Back-to-back inputs, then idle: output must hold the last result.
        @(posedge clk);
        #2 applyStimulus(BASE_WORD, 4'd1, 1'b1);
        @(posedge clk);
        #1 checkOutput("b2b_1", ROT1, 1'b1);
        #1 applyStimulus(BASE_WORD, 4'd2, 1'b1);
        @(posedge clk);
        #1 checkOutput("b2b_2", ROT2, 1'b1);
        #1 applyStimulus(BASE_WORD, 4'd3, 1'b1);
        @(posedge clk);
        #1 checkOutput("b2b_3", ROT3, 1'b1);
        #1 applyStimulus('x, 'x, 1'b0);
        @(posedge clk);
        #1 checkOutput("idle_hold", ROT3, 1'b0);
        @(posedge clk);
        #1 checkOutput("idle_x_hold", ROT3, 1'b0);

        // Reset between edges while a result is valid.
        #1 applyStimulus(BASE_WORD, 4'd5, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 checkOutput("reset_mid", '0, 1'b0);
        applyStimulus('0, '0, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 checkOutput("post_reset_idle", '0, 1'b0);
`else
        stepCheck("b2b_1", 4'd1, ROT1);
        stepCheck("b2b_2", 4'd2, ROT2);
        stepCheck("b2b_3", 4'd3, ROT3);
`endif

        // Random sweep; the per-cycle compare process does the checking.
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #2;
            w = {$urandom, $urandom, $urandom, $urandom};
            a = SA_W'($urandom_range(0, L - 1));
            applyStimulus(w, a, ($urandom_range(0, 3) != 0));
            pkg_res = N'(rot_bytes_r(MAX_N'(w), int'(a), N));
            checks++;
            if (pkg_res !== model_rot(w, int'(a))) begin
                errors++;
                $display("[TB] FAIL pkg_ref: got %h want %h", pkg_res, model_rot(w, int'(a)));
            end
        end

        @(posedge clk);
        #2 applyStimulus('0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #1ms;
        $display("[TB] FAIL timeout: got running want finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
